// File: rtl/vote_logger_if.sv
// Bundled voting/readout signals for vote_logger; the bench drives the master side.
// valid_vote carries one-cycle pulses with no back-pressure; the block answers each pulse cycle with exactly one of vote_ack or vote_reject one cycle later.
interface vote_logger_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
);
    localparam int SEL_W = $clog2(NUM_CAND);

    logic                mode;
    logic [NUM_CAND-1:0] valid_vote;
    logic [SEL_W-1:0]    cand_sel;
    logic                vote_ack;
    logic                vote_reject;
    logic                busy;
    logic [CNT_W-1:0]    count_out;
    logic [CNT_W-1:0]    total_out;
    logic [1:0]          state_dbg;

    modport master (
        output mode, valid_vote, cand_sel,
        input  vote_ack, vote_reject, busy, count_out, total_out, state_dbg
    );

    modport slave (
        input  mode, valid_vote, cand_sel,
        output vote_ack, vote_reject, busy, count_out, total_out, state_dbg
    );
endinterface

// File: rtl/vote_logger.sv
// Per-candidate vote counter with post-vote lockout and registered result readout.
// Define VOTE_LOGGER_SATURATE_EN to saturate counters; otherwise they wrap.
module vote_logger #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 4
) (
    input  logic          clock,
    input  logic          reset,
    vote_logger_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_CAND);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKOUT = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [3:0]       lock_cnt, lock_nxt;
    logic [CNT_W-1:0] cnt_q [NUM_CAND];
    logic [CNT_W-1:0] total_q;
    logic             ack_q, rej_q;
    logic [CNT_W-1:0] count_q, total_out_q;
    logic             any_vote, one_vote, accept, reject;
    logic [CNT_W-1:0] sel_cnt;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef VOTE_LOGGER_SATURATE_EN
        return (&v) ? v : v + CNT_W'(1);
`else
        return v + CNT_W'(1);
`endif
    endfunction

    assign any_vote = |bus.valid_vote;
    assign one_vote = any_vote &&
                      ((bus.valid_vote & (bus.valid_vote - NUM_CAND'(1))) == '0);

    // Out-of-range cand_sel matches no candidate and reads back zero.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (bus.cand_sel == SEL_W'(i)) sel_cnt = cnt_q[i];
        end
    end

    always_comb begin
        next_state = state;
        lock_nxt   = lock_cnt;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mode) begin
                    next_state = RESULT;
                    reject     = any_vote;
                end else if (one_vote) begin
                    accept     = 1'b1;
                    next_state = LOCKOUT;
                    lock_nxt   = 4'(LOCK_CYCLES - 1);
                end else begin
                    reject     = any_vote;
                end
            end
            LOCKOUT: begin
                reject = any_vote;
                if (lock_cnt == 4'd0) next_state = bus.mode ? RESULT : IDLE;
                else                  lock_nxt   = lock_cnt - 4'd1;
            end
            RESULT: begin
                reject = any_vote;
                if (!bus.mode) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= next_state;
            lock_cnt <= lock_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
            total_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (bus.valid_vote[i]) cnt_q[i] <= bump(cnt_q[i]);
            end
            total_q <= bump(total_q);
        end
    end

    // Readout registers load on entry to RESULT so the first RESULT cycle is already valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_q       <= 1'b0;
            rej_q       <= 1'b0;
            count_q     <= '0;
            total_out_q <= '0;
        end else begin
            ack_q <= accept;
            rej_q <= reject;
            if (next_state == RESULT) begin
                count_q     <= sel_cnt;
                total_out_q <= total_q;
            end else begin
                count_q     <= '0;
                total_out_q <= '0;
            end
        end
    end

    assign bus.vote_ack    = ack_q;
    assign bus.vote_reject = rej_q;
    assign bus.busy        = (state == LOCKOUT);
    assign bus.count_out   = count_q;
    assign bus.total_out   = total_out_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_vote_logger.sv
// Bench for vote_logger: directed scenarios plus random voting against a cycle-level reference model.
// Five candidates are used so cand_sel can address a non-existent candidate.
module tb_vote_logger;
  localparam int NC   = 5;
  localparam int CW   = 8;
  localparam int LC   = 4;
  localparam int SW   = $clog2(NC);
  localparam int W    = 3 + 2 * CW;
  localparam int MAXV = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  vote_logger_if #(.NUM_CAND(NC), .CNT_W(CW)) bus ();

  vote_logger #(.NUM_CAND(NC), .CNT_W(CW), .LOCK_CYCLES(LC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model: vote tallies plus remaining lockout cycles and readout flag
  int cnt_m [NC];
  int total_m;
  int lock_left;
  bit reading;
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bump_m(input int v);
`ifdef VOTE_LOGGER_SATURATE_EN
    return (v >= MAXV) ? MAXV : v + 1;
`else
    return (v + 1) % (MAXV + 1);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) cnt_m[i] = 0;
    total_m   = 0;
    lock_left = 0;
    reading   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic m, input logic [NC-1:0] vv, input logic [SW-1:0] sel);
    int  n;
    bit  e_ack, e_rej;
    int  e_cnt, e_tot;
    n     = $countones(vv);
    e_ack = 1'b0;
    e_rej = 1'b0;
    if (lock_left > 0) begin
      e_rej = (n > 0);
      lock_left--;
      if (lock_left == 0) reading = m;
    end else if (reading) begin
      e_rej = (n > 0);
      if (!m) reading = 1'b0;
    end else if (m) begin
      e_rej   = (n > 0);
      reading = 1'b1;
    end else if (n == 1) begin
      e_ack = 1'b1;
      for (int i = 0; i < NC; i++) if (vv[i]) cnt_m[i] = bump_m(cnt_m[i]);
      total_m   = bump_m(total_m);
      lock_left = LC;
    end else begin
      e_rej = (n > 1);
    end
    e_cnt = (reading && int'(sel) < NC) ? cnt_m[sel] : 0;
    e_tot = reading ? total_m : 0;
    exp_q.push_back({e_ack, e_rej, (lock_left > 0), CW'(e_cnt), CW'(e_tot)});
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    check("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("vote_ack",    32'(bus.vote_ack),    32'(e[W-1]));
      check("vote_reject", 32'(bus.vote_reject), 32'(e[W-2]));
      check("busy",        32'(bus.busy),        32'(e[W-3]));
      check("count_out",   32'(bus.count_out),   32'(e[2*CW-1:CW]));
      check("total_out",   32'(bus.total_out),   32'(e[CW-1:0]));
    end
  endtask

  task automatic drive_cycle(input logic m, input logic [NC-1:0] vv, input logic [SW-1:0] sel);
    bus.mode       = m;
    bus.valid_vote = vv;
    bus.cand_sel   = sel;
    model_step(m, vv, sel);
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   32'(bus.vote_ack),    32'd0);
    check({tag, "_rej"},   32'(bus.vote_reject), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),        32'd0);
    check({tag, "_count"}, 32'(bus.count_out),   32'd0);
    check({tag, "_total"}, 32'(bus.total_out),   32'd0);
  endtask

  // asserts reset asynchronously between edges, holds it over two edges, releases at a negedge
  task automatic apply_reset(input string tag);
    bus.valid_vote = '0;
    bus.mode       = 1'b0;
    #2 reset = 1'b0;
    #1 check_all_zero(tag);
    check({tag, "_state"}, 32'(bus.state_dbg), 32'd0);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero({tag, "_held"});
    reset = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input logic m);
    for (int i = 0; i < n; i++) drive_cycle(m, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] vv;
    logic          m;
    bus.mode       = 1'b0;
    bus.valid_vote = '0;
    bus.cand_sel   = '0;
    model_reset();

    // power-on reset
    #1 check_all_zero("por");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // single vote, lockout, readout of candidate 0
    drive_cycle(1'b0, 5'b00001, '0);
    check("r030_ack", 32'(bus.vote_ack), 32'd1);
    check("r030_busy1", 32'(bus.busy), 32'd1);
    idle_cycles(3, 1'b0);
    check("r030_busy4", 32'(bus.busy), 32'd1);
    drive_cycle(1'b1, '0, 3'd0);
    check("r030_busy_off", 32'(bus.busy), 32'd0);
    check("r030_count", 32'(bus.count_out), 32'd1);
    check("r030_total", 32'(bus.total_out), 32'd1);
    drive_cycle(1'b0, '0, '0);

    // multi-bit vote rejected
    apply_reset("rst_a");
    drive_cycle(1'b0, 5'b00110, '0);
    check("r031_rej", 32'(bus.vote_reject), 32'd1);
    check("r031_ack", 32'(bus.vote_ack), 32'd0);
    for (int s = 0; s < NC; s++) drive_cycle(1'b1, '0, SW'(s));
    check("r031_total", 32'(bus.total_out), 32'd0);
    drive_cycle(1'b0, '0, '0);

    // second vote during lockout rejected
    drive_cycle(1'b0, 5'b00010, '0);
    drive_cycle(1'b0, '0, '0);
    drive_cycle(1'b0, 5'b00010, '0);
    check("r032_rej", 32'(bus.vote_reject), 32'd1);
    idle_cycles(2, 1'b0);
    drive_cycle(1'b1, '0, 3'd1);
    check("r032_count", 32'(bus.count_out), 32'd1);
    drive_cycle(1'b1, '0, 3'd6);
    check("r021_oor", 32'(bus.count_out), 32'd0);
    drive_cycle(1'b0, '0, '0);

    // mode raised during lockout does not shorten it; vote in RESULT rejected
    drive_cycle(1'b0, 5'b00100, '0);
    idle_cycles(3, 1'b1);
    check("r033_busy", 32'(bus.busy), 32'd1);
    drive_cycle(1'b1, '0, 3'd2);
    check("r033_state", 32'(bus.state_dbg), 32'd2);
    drive_cycle(1'b1, 5'b00100, 3'd2);
    check("r033_rej", 32'(bus.vote_reject), 32'd1);
    check("r033_count", 32'(bus.count_out), 32'd1);
    drive_cycle(1'b0, '0, '0);

    // reset mid-lockout, then a fresh vote
    drive_cycle(1'b0, 5'b01000, '0);
    drive_cycle(1'b0, '0, '0);
    apply_reset("r035");
    drive_cycle(1'b0, '0, '0);
    check("r035_no_ack", 32'(bus.vote_ack), 32'd0);
    drive_cycle(1'b0, 5'b01000, '0);
    check("r035_ack", 32'(bus.vote_ack), 32'd1);
    idle_cycles(3, 1'b0);
    drive_cycle(1'b1, '0, 3'd3);
    check("r035_count", 32'(bus.count_out), 32'd1);
    drive_cycle(1'b0, '0, '0);

    // random traffic
    m = 1'b0;
    for (int c = 0; c < 800; c++) begin
      int r;
      if ($urandom_range(0, 15) == 0) m = ~m;
      r = $urandom_range(0, 9);
      if (r < 5)      vv = '0;
      else if (r < 8) vv = NC'(1) << $urandom_range(0, NC - 1);
      else            vv = NC'($urandom_range(1, (1 << NC) - 1));
      drive_cycle(m, vv, SW'($urandom_range(0, (1 << SW) - 1)));
    end

    // 256 accepted votes on candidate 3
    apply_reset("rst_sat");
    for (int v = 0; v < 256; v++) begin
      drive_cycle(1'b0, 5'b01000, '0);
      idle_cycles(LC, 1'b0);
    end
    drive_cycle(1'b1, '0, 3'd3);
`ifdef VOTE_LOGGER_SATURATE_EN
    check("r034_count", 32'(bus.count_out), 32'd255);
    check("r034_total", 32'(bus.total_out), 32'd255);
`else
    check("r034_count", 32'(bus.count_out), 32'd0);
    check("r034_total", 32'(bus.total_out), 32'd0);
`endif
    drive_cycle(1'b0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
